// File: rtl/instr_loader.sv
// instr_loader: packs a host byte stream into 32-bit words and writes instruction memory from address 0.
// Define OPCHECK_EN to flag words whose opcode is outside the supported MIPS subset.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, FIN} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, wc_q, wc_d;
  logic [1:0] bc_q, bc_d;
  logic [31:0] sh_q, sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic err_q, err_d, fire, ovf, last, bad_op;
  assign in_ready = (state_q == HDR) || (state_q == DATA);
  assign fire = in_valid & in_ready;
  assign ovf = 32'(wc_q) >= (32'd1 << ADDR_W);
  assign last = (wc_q + 16'd1) == cnt_q;
`ifdef OPCHECK_EN
  assign bad_op = !(sh_q[31:26] inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b001100, 6'b000100, 6'b000011});
`else
  assign bad_op = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wc_d = wc_q;
    bc_d = bc_q;
    sh_d = sh_q;
    addr_d = addr_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR;
        err_d = 1'b0;
        cnt_d = '0;
        wc_d = '0;
        bc_d = '0;
        addr_d = '0;
      end
      HDR: if (fire) begin
        cnt_d = {cnt_q[7:0], in_byte};
        bc_d = bc_q[0] ? 2'd0 : 2'd1;
        if (bc_q[0]) state_d = (cnt_d == 16'd0) ? FIN : DATA;
      end
      DATA: if (fire) begin
        sh_d = {sh_q[23:0], in_byte};
        bc_d = bc_q + 2'd1;
        if (bc_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        wc_d = wc_q + 16'd1;
        // saturate so overflowed words never alias low addresses
        addr_d = (addr_q == '1) ? addr_q : addr_q + 1'b1;
        err_d = err_q | ovf | bad_op;
        state_d = last ? FIN : DATA;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wc_q <= '0;
      bc_q <= '0;
      sh_q <= '0;
      addr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wc_q <= wc_d;
      bc_q <= bc_d;
      sh_q <= sh_d;
      addr_q <= addr_d;
      err_q <= err_d;
    end
  end
  assign imem_we = (state_q == WRITE) && !ovf;
  assign imem_addr = addr_q;
  assign imem_wdata = sh_q;
  assign busy = state_q != IDLE;
  assign cpu_hold = state_q != IDLE;
  assign done = state_q == FIN;
  assign err = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench driving an ADDR_W=8 and an ADDR_W=2 loader with the same byte streams.
module tb_instr_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic [1:0] rdy, we, hold, bsy, dn, er;
  logic [7:0] ad [2];
  logic [31:0] wd [2];
  logic [1:0] a2;
  int checks = 0, errors = 0, cyc = 0, st_cyc = 0;
`ifdef OPCHECK_EN
  localparam bit OPC = 1'b1;
`else
  localparam bit OPC = 1'b0;
`endif
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  typedef struct packed {logic e; int l;} dn_t;
  wr_t wq8[$], wq2[$];
  dn_t dq8[$], dq2[$];
  bit pend [2] = '{1'b0, 1'b0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ad[1] = {6'd0, a2};
  instr_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy[0]), .imem_we(we[0]), .imem_addr(ad[0]), .imem_wdata(wd[0]),
    .cpu_hold(hold[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]));
  instr_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy[1]), .imem_we(we[1]), .imem_addr(a2), .imem_wdata(wd[1]),
    .cpu_hold(hold[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic abort(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask
  always @(negedge clk) if (!rst) for (int i = 0; i < 2; i++) begin
    wr_t w;
    dn_t d;
    if (pend[i]) begin
      chk($sformatf("hold_drop%0d", i), {30'd0, hold[i], bsy[i]}, 32'd0);
      pend[i] = 1'b0;
    end
    if (we[i]) begin
      if ((i == 0 ? wq8.size() : wq2.size()) == 0) chk($sformatf("unexpected_write%0d", i), 32'd1, 32'd0);
      else begin
        if (i == 0) w = wq8.pop_front(); else w = wq2.pop_front();
        chk($sformatf("waddr%0d", i), {24'd0, ad[i]}, {24'd0, w.a});
        chk($sformatf("wdata%0d", i), wd[i], w.d);
      end
    end
    if (dn[i]) begin
      if ((i == 0 ? dq8.size() : dq2.size()) == 0) chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
      else begin
        if (i == 0) d = dq8.pop_front(); else d = dq2.pop_front();
        chk($sformatf("done_err%0d", i), {31'd0, er[i]}, {31'd0, d.e});
        if (d.l != 0) chk($sformatf("done_latency%0d", i), cyc - st_cyc, d.l);
        chk($sformatf("done_hold%0d", i), {31'd0, hold[i]}, 32'd1);
        pend[i] = 1'b1;
      end
    end
  end
  task automatic ew(input logic [7:0] a, input logic [31:0] d);
    wq8.push_back('{a: a, d: d});
    if (a < 8'd4) wq2.push_back('{a: a, d: d});
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte = b;
    for (int t = 0; !rdy[0]; t++) begin
      if (t > 50) abort("handshake");
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic kick();
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input logic [7:0] s[$], input bit gap, input bit e8, input bit e2, input int lat);
    dq8.push_back('{e: e8, l: lat});
    dq2.push_back('{e: e2, l: lat});
    kick();
    foreach (s[k]) send(s[k], gap);
    in_valid = 1'b0;
    for (int t = 0; bsy != 2'b00; t++) begin
      if (t > 200) abort("load_end");
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ctrl%0d", i), {26'd0, rdy[i], we[i], hold[i], bsy[i], dn[i], er[i]}, 32'd0);
      chk($sformatf("reset_addr%0d", i), {24'd0, ad[i]}, 32'd0);
      chk($sformatf("reset_wdata%0d", i), wd[i], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    ew(8'd0, 32'h8C080004);
    ew(8'd1, 32'h00000000);
    run('{8'h00, 8'h02, 8'h8C, 8'h08, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 13);
    run('{8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 3);
    ew(8'd0, 32'h8C080004);
    ew(8'd1, 32'h00000000);
    run('{8'h00, 8'h02, 8'h8C, 8'h08, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) ew(8'(k), 32'(k + 1));
    run('{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03,
          8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05}, 1'b0, 1'b0, 1'b1, 28);
    ew(8'd0, 32'hFC000000);
    run('{8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00}, 1'b0, OPC, OPC, 8);
    kick();
    foreach (bytes_q[k]) send(bytes_q[k], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midload_reset_busy", {30'd0, bsy}, 32'd0);
    chk("midload_reset_hold", {30'd0, hold}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ew(8'd0, 32'h2008FFFF);
    run('{8'h00, 8'h01, 8'h20, 8'h08, 8'hFF, 8'hFF}, 1'b0, 1'b0, 1'b0, 8);
    chk("leftover_writes8", wq8.size(), 32'd0);
    chk("leftover_writes2", wq2.size(), 32'd0);
    chk("leftover_done8", dq8.size(), 32'd0);
    chk("leftover_done2", dq2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  logic [7:0] bytes_q[$] = '{8'h00, 8'h01, 8'hAA, 8'hBB};
endmodule
